// File: rtl/inst_mem.sv
// inst_mem: read-only instruction ROM with combinational fetch, a registered
// copy of the fetched word and a word-alignment error flag.
module inst_mem #(
    parameter int          DEPTH    = 64,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic [31:0] addr,
    output logic [31:0] inst,
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] inst_q,
    output logic        addr_misaligned
);
    logic [31:0] word;
    always_comb begin
        case (addr[7:2])
            6'd0:    word = 32'h00100293;
            6'd1:    word = 32'h00300313;
            6'd2:    word = 32'h0062B223;
            6'd3:    word = 32'h0062E3B3;
            6'd4:    word = 32'h0053B123;
            6'd5:    word = 32'h0042B303;
            6'd6:    word = 32'h00628263;
            6'd7:    word = 32'h006282B3;
            6'd8:    word = 32'h405383B3;
            default: word = NOP_WORD;
        endcase
    end
    // Anything at or above 256 bytes, or beyond DEPTH, fetches a NOP
    assign inst = (addr[31:8] == '0 && int'(addr[7:2]) < DEPTH) ? word : NOP_WORD;
    assign addr_misaligned = addr[1:0] != 2'b00;
    always_ff @(posedge clk or negedge reset)
        if (!reset) inst_q <= NOP_WORD;
        else        inst_q <= inst;
endmodule

// File: tb/tb_inst_mem.sv
// tb_inst_mem: directed and randomized checks of inst_mem against a
// behavioural ROM model.
module tb_inst_mem;
    localparam logic [31:0] NOP = 32'h00000013;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_q;
    logic        addr_misaligned;
    int          cmp = 0;
    int          bad = 0;
    logic [31:0] rom [64];
    logic [31:0] prog [9] = '{32'h00100293, 32'h00300313, 32'h0062B223,
                              32'h0062E3B3, 32'h0053B123, 32'h0042B303,
                              32'h00628263, 32'h006282B3, 32'h405383B3};
    logic [31:0] exp_q;
    logic [31:0] far [4] = '{32'h24, 32'hFC, 32'h100, 32'hFFFFFFFC};

    inst_mem dut (
        .addr(addr), .inst(inst), .clk(clk), .reset(reset),
        .inst_q(inst_q), .addr_misaligned(addr_misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_inst(input logic [31:0] a);
        return (a > 32'd255) ? NOP : rom[a[7:2]];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        cmp++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = (i < 9) ? prog[i] : NOP;
        reset = 1'b0;
        addr = 32'h0;
        @(posedge clk); #1;
        check("reset_q", inst_q, NOP);
        reset = 1'b1;
        for (int i = 0; i < 9; i++) begin
            addr = i * 4;
            #1;
            check($sformatf("seq_inst_%0d", i), inst, prog[i]);
            check($sformatf("seq_mis_%0d", i), {31'b0, addr_misaligned}, 32'd0);
            #4;
        end
        for (int i = 0; i < 4; i++) begin
            addr = far[i];
            #1;
            check($sformatf("nop_%h", far[i]), inst, NOP);
        end
        addr = 32'h06;
        #1;
        check("mis_inst_06", inst, 32'h00300313);
        check("mis_flag_06", {31'b0, addr_misaligned}, 32'd1);
        addr = 32'h08;
        #1;
        check("mis_flag_08", {31'b0, addr_misaligned}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("hold_reset_q", inst_q, NOP);
        @(negedge clk);
        addr = 32'h0C;
        reset = 1'b1;
        @(posedge clk); #1;
        check("first_capture", inst_q, 32'h0062E3B3);
        @(negedge clk);
        addr = 32'h20;
        #1;
        check("q_holds", inst_q, 32'h0062E3B3);
        @(posedge clk); #1;
        check("q_next", inst_q, 32'h405383B3);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        check("async_q", inst_q, NOP);
        check("async_inst", inst, 32'h405383B3);
        @(posedge clk); #1;
        check("reset_held_q", inst_q, NOP);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("recapture", inst_q, 32'h405383B3);
        @(negedge clk);
        reset = 1'b0;
        addr = 32'h04;
        #1;
        check("same_ts_q", inst_q, NOP);
        check("same_ts_inst", inst, 32'h00300313);
        exp_q = NOP;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0: addr = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
                1: addr = $urandom_range(0, 255);
                2: addr = $urandom;
                default: addr = $urandom_range(256, 300);
            endcase
            reset = ($urandom_range(0, 15) != 0);
            #1;
            check("rnd_inst", inst, ref_inst(addr));
            check("rnd_mis", {31'b0, addr_misaligned}, {31'b0, addr[1:0] != 2'b00});
            if (!reset) exp_q = NOP;
            check("rnd_q_mid", inst_q, exp_q);
            @(posedge clk);
            if (reset) exp_q = ref_inst(addr);
            #1;
            check("rnd_q", inst_q, exp_q);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
